// File: rtl/wb_writeback.sv
// ============================================================================
// Module      : wb_writeback
// Description : Writeback stage. It holds one ALU or load result, stalls the
//               pipeline while load data is outstanding, and bypasses the
//               result to the ID read ports. Sub-word load alignment is
//               enabled by the macro WB_LOAD_ALIGN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_writeback (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Valid_MEM,
  input  logic        RegWrite_MEM,
  input  logic        MemToReg_MEM,
  input  logic [4:0]  Write_Register_MEM,
  input  logic [31:0] ALU_Result_MEM,
  input  logic [1:0]  Load_Size_MEM,
  input  logic        Load_Signed_MEM,
  input  logic [31:0] Mem_Rdata,
  input  logic        Mem_Rdata_Valid,
  input  logic        Flush_WB,
  input  logic [4:0]  Read_Address_1_ID,
  input  logic [4:0]  Read_Address_2_ID,
  output logic [4:0]  Write_Register_WB,
  output logic [31:0] Write_Data_WB,
  output logic        RegWrite_WB,
  output logic [1:0]  ID_Register_Write_to_Read,
  output logic        Stall_WB
);

  localparam logic [1:0] S_EMPTY      = 2'd0;
  localparam logic [1:0] S_ALU_READY  = 2'd1;
  localparam logic [1:0] S_LOAD_WAIT  = 2'd2;
  localparam logic [1:0] S_LOAD_READY = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  dest_q, dest_d;
  logic        regwr_q, regwr_d;
  logic [31:0] data_q, data_d;

`ifdef WB_LOAD_ALIGN_EN
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;

  // Lanes are little-endian; size 2'b11 falls through to a full word.
  function automatic logic [31:0] f_align(input logic [31:0] word,
                                          input logic [1:0]  off,
                                          input logic [1:0]  size,
                                          input logic        sgn);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half   = off[1] ? word[31:16] : word[15:0];
    byte_v = word[8*off +: 8];
    case (size)
      2'b01:   f_align = {{16{sgn & half[15]}}, half};
      2'b10:   f_align = {{24{sgn & byte_v[7]}}, byte_v};
      default: f_align = word;
    endcase
  endfunction
`else
  logic w_unused_align;
  assign w_unused_align = ^{Load_Size_MEM, Load_Signed_MEM};
`endif

  // State and held-field registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_EMPTY;
      dest_q  <= 5'd0;
      regwr_q <= 1'b0;
      data_q  <= 32'd0;
`ifdef WB_LOAD_ALIGN_EN
      off_q   <= 2'd0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      regwr_q <= regwr_d;
      data_q  <= data_d;
`ifdef WB_LOAD_ALIGN_EN
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
`endif
    end
  end

  // Next-state and held-field update
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    regwr_d = regwr_q;
    data_d  = data_q;
`ifdef WB_LOAD_ALIGN_EN
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
`endif
    if (Flush_WB) begin
      state_d = S_EMPTY;
    end else if (state_q == S_LOAD_WAIT) begin
      if (Mem_Rdata_Valid) begin
`ifdef WB_LOAD_ALIGN_EN
        data_d = f_align(Mem_Rdata, off_q, size_q, sgn_q);
`else
        data_d = Mem_Rdata;
`endif
        state_d = S_LOAD_READY;
      end
    end else if (!Valid_MEM) begin
      state_d = S_EMPTY;
    end else begin
      dest_d  = Write_Register_MEM;
      regwr_d = RegWrite_MEM;
`ifdef WB_LOAD_ALIGN_EN
      off_d   = ALU_Result_MEM[1:0];
      size_d  = Load_Size_MEM;
      sgn_d   = Load_Signed_MEM;
`endif
      if (!MemToReg_MEM) begin
        data_d  = ALU_Result_MEM;
        state_d = S_ALU_READY;
      end else if (Mem_Rdata_Valid) begin
`ifdef WB_LOAD_ALIGN_EN
        data_d = f_align(Mem_Rdata, ALU_Result_MEM[1:0], Load_Size_MEM, Load_Signed_MEM);
`else
        data_d = Mem_Rdata;
`endif
        state_d = S_LOAD_READY;
      end else begin
        state_d = S_LOAD_WAIT;
      end
    end
  end

  // Outputs decoded from state and held fields
  always_comb begin
    Stall_WB    = (state_q == S_LOAD_WAIT);
    RegWrite_WB = ((state_q == S_ALU_READY) || (state_q == S_LOAD_READY))
                  && regwr_q && (dest_q != 5'd0);
    ID_Register_Write_to_Read[0] = RegWrite_WB && (dest_q == Read_Address_1_ID)
                                   && (Read_Address_1_ID != 5'd0);
    ID_Register_Write_to_Read[1] = RegWrite_WB && (dest_q == Read_Address_2_ID)
                                   && (Read_Address_2_ID != 5'd0);
  end

  assign Write_Register_WB = dest_q;
  assign Write_Data_WB     = data_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_writeback.sv
// Directed, table-driven bench for wb_writeback plus hand-written reset sequences.
`default_nettype none

module tb_wb_writeback;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Valid_MEM, RegWrite_MEM, MemToReg_MEM;
  logic [4:0]  Write_Register_MEM;
  logic [31:0] ALU_Result_MEM;
  logic [1:0]  Load_Size_MEM;
  logic        Load_Signed_MEM;
  logic [31:0] Mem_Rdata;
  logic        Mem_Rdata_Valid, Flush_WB;
  logic [4:0]  Read_Address_1_ID, Read_Address_2_ID;
  logic [4:0]  Write_Register_WB;
  logic [31:0] Write_Data_WB;
  logic        RegWrite_WB;
  logic [1:0]  ID_Register_Write_to_Read;
  logic        Stall_WB;

  int n_chk  = 0;
  int n_fail = 0;

  wb_writeback dut (
    .Clk(Clk), .Reset_n(Reset_n), .Valid_MEM(Valid_MEM), .RegWrite_MEM(RegWrite_MEM),
    .MemToReg_MEM(MemToReg_MEM), .Write_Register_MEM(Write_Register_MEM),
    .ALU_Result_MEM(ALU_Result_MEM), .Load_Size_MEM(Load_Size_MEM),
    .Load_Signed_MEM(Load_Signed_MEM), .Mem_Rdata(Mem_Rdata),
    .Mem_Rdata_Valid(Mem_Rdata_Valid), .Flush_WB(Flush_WB),
    .Read_Address_1_ID(Read_Address_1_ID), .Read_Address_2_ID(Read_Address_2_ID),
    .Write_Register_WB(Write_Register_WB), .Write_Data_WB(Write_Data_WB),
    .RegWrite_WB(RegWrite_WB), .ID_Register_Write_to_Read(ID_Register_Write_to_Read),
    .Stall_WB(Stall_WB)
  );

  always #5 Clk = ~Clk;

`ifdef WB_LOAD_ALIGN_EN
  localparam logic [31:0] X_SB3 = 32'hFFFF_FF80;
  localparam logic [31:0] X_UH2 = 32'h0000_80FF;
  localparam logic [31:0] X_SB1 = 32'h0000_007F;
  localparam logic [31:0] X_SH2 = 32'hFFFF_80FF;
`else
  localparam logic [31:0] X_SB3 = 32'h80FF_7F01;
  localparam logic [31:0] X_UH2 = 32'h80FF_7F01;
  localparam logic [31:0] X_SB1 = 32'h80FF_7F01;
  localparam logic [31:0] X_SH2 = 32'h80FF_7F01;
`endif
  localparam logic [31:0] RD = 32'h80FF_7F01;

  typedef struct {
    logic        v, rw, m2r;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] rd;
    logic        rdv, fl;
    logic [4:0]  ra1, ra2;
    logic        e_rw;
    logic        chk_wr;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_st;
    logic [1:0]  e_byp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, rw, m2r, input logic [4:0] dest, input logic [31:0] alu,
                     input logic [1:0] sz, input logic sg, input logic [31:0] rd,
                     input logic rdv, fl, input logic [4:0] ra1, ra2,
                     input logic e_rw, chk_wr, input logic [4:0] e_wr,
                     input logic [31:0] e_wd, input logic e_st, input logic [1:0] e_byp);
    vec_t t;
    t.v = v; t.rw = rw; t.m2r = m2r; t.dest = dest; t.alu = alu; t.sz = sz; t.sg = sg;
    t.rd = rd; t.rdv = rdv; t.fl = fl; t.ra1 = ra1; t.ra2 = ra2;
    t.e_rw = e_rw; t.chk_wr = chk_wr; t.e_wr = e_wr; t.e_wd = e_wd; t.e_st = e_st;
    t.e_byp = e_byp;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    Valid_MEM = t.v; RegWrite_MEM = t.rw; MemToReg_MEM = t.m2r;
    Write_Register_MEM = t.dest; ALU_Result_MEM = t.alu; Load_Size_MEM = t.sz;
    Load_Signed_MEM = t.sg; Mem_Rdata = t.rd; Mem_Rdata_Valid = t.rdv; Flush_WB = t.fl;
    Read_Address_1_ID = t.ra1; Read_Address_2_ID = t.ra2;
  endtask

  task automatic drive_alu(input logic [4:0] dest, input logic [31:0] val, input logic [4:0] ra1);
    Valid_MEM = 1'b1; RegWrite_MEM = 1'b1; MemToReg_MEM = 1'b0; Write_Register_MEM = dest;
    ALU_Result_MEM = val; Load_Size_MEM = 2'b00; Load_Signed_MEM = 1'b0;
    Mem_Rdata = 32'd0; Mem_Rdata_Valid = 1'b0; Flush_WB = 1'b0;
    Read_Address_1_ID = ra1; Read_Address_2_ID = 5'd0;
  endtask

  task automatic chk_all(input string tag, input logic rw, input logic [4:0] wr,
                         input logic [31:0] wd, input logic st, input logic [1:0] byp);
    chk({tag, ".RegWrite_WB"}, {31'd0, RegWrite_WB}, {31'd0, rw});
    chk({tag, ".Write_Register_WB"}, {27'd0, Write_Register_WB}, {27'd0, wr});
    chk({tag, ".Write_Data_WB"}, Write_Data_WB, wd);
    chk({tag, ".Stall_WB"}, {31'd0, Stall_WB}, {31'd0, st});
    chk({tag, ".Bypass"}, {30'd0, ID_Register_Write_to_Read}, {30'd0, byp});
  endtask

  initial begin
    //  v  rw m2r dest alu            sz    sg rd             rdv fl ra1 ra2 | rw chk wr wd            st byp
    add(1, 1, 0, 5,  32'h1234_5678, 2'd0, 0, 32'd0,         0, 0, 5,  0,   1, 1, 5,  32'h1234_5678, 0, 2'b01);
    add(1, 1, 0, 7,  32'hA5A5_A5A5, 2'd0, 0, 32'd0,         0, 0, 7,  3,   1, 1, 7,  32'hA5A5_A5A5, 0, 2'b01);
    add(1, 1, 0, 7,  32'h11,        2'd0, 0, 32'd0,         0, 0, 7,  7,   1, 1, 7,  32'h11,        0, 2'b11);
    add(1, 1, 0, 0,  32'h22,        2'd0, 0, 32'd0,         0, 0, 0,  0,   0, 1, 0,  32'h22,        0, 2'b00);
    add(1, 0, 0, 8,  32'h33,        2'd0, 0, 32'd0,         0, 0, 8,  8,   0, 1, 8,  32'h33,        0, 2'b00);
    add(0, 1, 0, 9,  32'h44,        2'd0, 0, 32'd0,         0, 0, 8,  8,   0, 1, 8,  32'h33,        0, 2'b00);
    add(1, 1, 1, 10, 32'h103,       2'd2, 1, RD,            1, 0, 10, 0,   1, 1, 10, X_SB3,         0, 2'b01);
    add(1, 1, 1, 11, 32'h2,         2'd1, 0, RD,            1, 0, 0,  11,  1, 1, 11, X_UH2,         0, 2'b10);
    add(1, 1, 1, 12, 32'h1,         2'd2, 1, RD,            1, 0, 0,  0,   1, 1, 12, X_SB1,         0, 2'b00);
    add(1, 1, 1, 13, 32'h6,         2'd1, 1, RD,            1, 0, 0,  0,   1, 1, 13, X_SH2,         0, 2'b00);
    add(0, 1, 1, 14, 32'h0,         2'd0, 0, 32'hDEAD_BEEF, 1, 0, 0,  0,   0, 1, 13, X_SH2,         0, 2'b00);
    // load to 9 stalls three cycles; MEM holds a different instruction meanwhile
    add(1, 1, 1, 9,  32'h0,         2'd0, 0, 32'd0,         0, 0, 9,  0,   0, 0, 0,  X_SH2,         1, 2'b00);
    add(1, 1, 0, 20, 32'h5555_5555, 2'd0, 0, 32'd0,         0, 0, 9,  0,   0, 0, 0,  X_SH2,         1, 2'b00);
    add(1, 1, 0, 20, 32'h5555_5555, 2'd0, 0, 32'd0,         0, 0, 9,  0,   0, 0, 0,  X_SH2,         1, 2'b00);
    add(0, 0, 0, 0,  32'h0,         2'd0, 0, 32'hCAFE_F00D, 1, 0, 9,  0,   1, 1, 9,  32'hCAFE_F00D, 0, 2'b01);
    add(0, 0, 0, 0,  32'h0,         2'd0, 0, 32'd0,         0, 0, 9,  0,   0, 1, 9,  32'hCAFE_F00D, 0, 2'b00);
    // flush in LOAD_WAIT beats arriving data; later data is ignored
    add(1, 1, 1, 14, 32'h0,         2'd0, 0, 32'd0,         0, 0, 0,  0,   0, 0, 0,  32'hCAFE_F00D, 1, 2'b00);
    add(1, 1, 1, 14, 32'h0,         2'd0, 0, 32'h0001_2345, 1, 1, 0,  0,   0, 0, 0,  32'hCAFE_F00D, 0, 2'b00);
    add(0, 0, 0, 0,  32'h0,         2'd0, 0, 32'h0000_DEAD, 1, 0, 0,  0,   0, 0, 0,  32'hCAFE_F00D, 0, 2'b00);
    add(1, 1, 0, 3,  32'h77,        2'd0, 0, 32'd0,         0, 1, 0,  0,   0, 0, 0,  32'hCAFE_F00D, 0, 2'b00);
    add(1, 1, 0, 3,  32'h77,        2'd0, 0, 32'd0,         0, 0, 3,  3,   1, 1, 3,  32'h77,        0, 2'b11);
    // size 2'b11 is a full word in either build
    add(1, 1, 1, 4,  32'h3,         2'd3, 1, RD,            1, 0, 0,  4,   1, 1, 4,  RD,            0, 2'b10);

    Reset_n = 1'b0;
    drive_alu(5'd0, 32'd0, 5'd0);
    Valid_MEM = 1'b0;
    repeat (2) @(negedge Clk);
    chk_all("reset", 1'b0, 5'd0, 32'd0, 1'b0, 2'b00);
    Reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge Clk); #1;
      chk($sformatf("v%0d.RegWrite_WB", i), {31'd0, RegWrite_WB}, {31'd0, vecs[i].e_rw});
      if (vecs[i].chk_wr)
        chk($sformatf("v%0d.Write_Register_WB", i), {27'd0, Write_Register_WB}, {27'd0, vecs[i].e_wr});
      chk($sformatf("v%0d.Write_Data_WB", i), Write_Data_WB, vecs[i].e_wd);
      chk($sformatf("v%0d.Stall_WB", i), {31'd0, Stall_WB}, {31'd0, vecs[i].e_st});
      chk($sformatf("v%0d.Bypass", i), {30'd0, ID_Register_Write_to_Read}, {30'd0, vecs[i].e_byp});
      @(negedge Clk);
    end

    // asynchronous reset in ALU_READY clears outputs without a clock edge
    drive_alu(5'd5, 32'h1234_5678, 5'd5);
    @(posedge Clk); #1;
    chk_all("alu_before_rst", 1'b1, 5'd5, 32'h1234_5678, 1'b0, 2'b01);
    #2 Reset_n = 1'b0;
    #1 chk_all("async_rst", 1'b0, 5'd0, 32'd0, 1'b0, 2'b00);
    @(negedge Clk);
    drive_alu(5'd6, 32'h66, 5'd6);
    @(posedge Clk); #1;
    chk_all("rst_held", 1'b0, 5'd0, 32'd0, 1'b0, 2'b00);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    chk_all("first_capture", 1'b1, 5'd6, 32'h66, 1'b0, 2'b01);

    // reset during LOAD_WAIT abandons the load
    @(negedge Clk);
    drive_alu(5'd9, 32'h0, 5'd0);
    MemToReg_MEM = 1'b1;
    @(posedge Clk); #1;
    chk("lw_stall", {31'd0, Stall_WB}, 32'd1);
    #2 Reset_n = 1'b0;
    #1 chk("lw_rst_stall", {31'd0, Stall_WB}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    Valid_MEM = 1'b0; Mem_Rdata = 32'hCAFE_F00D; Mem_Rdata_Valid = 1'b1;
    @(posedge Clk); #1;
    chk_all("lw_rst_late_data", 1'b0, 5'd0, 32'd0, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_writeback.md
WB_WRITEBACK -- requirements
Module: wb_writeback

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
- Clk  input  1  single clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Valid_MEM  input  1  a MEM-stage instruction is presented this cycle.
- RegWrite_MEM  input  1  the instruction writes a register.
- MemToReg_MEM  input  1  the instruction is a load; write data comes from memory.
- Write_Register_MEM  input  5  destination register.
- ALU_Result_MEM  input  32  ALU result; bits [1:0] are the load byte offset.
- Load_Size_MEM  input  2  00 word, 01 half, 10 byte, 11 treated as word.
- Load_Signed_MEM  input  1  sign-extend a sub-word load.
- Mem_Rdata  input  32  data-memory read word.
- Mem_Rdata_Valid  input  1  Mem_Rdata is valid this cycle.
- Flush_WB  input  1  discard the held or pending instruction.
- Read_Address_1_ID  input  5  ID read port 1 address.
- Read_Address_2_ID  input  5  ID read port 2 address.
- Write_Register_WB  output  5  register-file write address.
- Write_Data_WB  output  32  register-file write data.
- RegWrite_WB  output  1  register-file write enable.
- ID_Register_Write_to_Read  output  2  bit0: bypass Write_Data_WB to read port 1; bit1: bypass to read port 2.
- Stall_WB  output  1  upstream pipeline must hold the MEM stage.

Function
REQ-002 The FSM SHALL have the states EMPTY, ALU_READY, LOAD_WAIT and LOAD_READY; it SHALL hold state, destination, RegWrite and Write_Data_WB in registers.
REQ-003 Stall_WB SHALL be 1 exactly when state is LOAD_WAIT, decoded combinationally from state.
REQ-004 Priority at each rising edge:
- Flush_WB=1: next state EMPTY; an outstanding load is abandoned.
- Else if LOAD_WAIT and Mem_Rdata_Valid=1: capture the aligned data; go to LOAD_READY.
- Else if LOAD_WAIT: stay in LOAD_WAIT; all held fields are unchanged.
- Else if Valid_MEM=0: go to EMPTY.
- Else capture Write_Register_MEM, RegWrite_MEM, ALU_Result_MEM[1:0], Load_Size_MEM and Load_Signed_MEM, then:
  - MemToReg_MEM=0: Write_Data_WB takes ALU_Result_MEM; go to ALU_READY.
  - MemToReg_MEM=1 and Mem_Rdata_Valid=1: capture the aligned data; go to LOAD_READY.
  - MemToReg_MEM=1 and Mem_Rdata_Valid=0: go to LOAD_WAIT.
REQ-005 RegWrite_WB SHALL be 1 exactly when all of the following hold:
- state is ALU_READY or LOAD_READY;
- held RegWrite is 1;
- held destination is nonzero.
REQ-006 A write to register 0 SHALL never assert RegWrite_WB.
REQ-007 Latency: an ALU instruction captured at edge N SHALL drive RegWrite_WB during cycle N..N+1; the register file commits it at edge N+1.
REQ-008 A load with Mem_Rdata_Valid first seen at edge M SHALL assert RegWrite_WB during cycle M..M+1.
REQ-009 Each READY state SHALL last one cycle unless a new instruction is captured; back-to-back ALU instructions SHALL sustain one writeback per cycle.
REQ-010 ID_Register_Write_to_Read[k] SHALL be combinational and equal 1 exactly when all of the following hold:
- RegWrite_WB=1;
- Write_Register_WB equals the port-k read address;
- that address is nonzero.
REQ-011 Load alignment:
- Lanes are little-endian; lane i is bits [8i+7:8i].
- Byte load: selects the lane given by offset[1:0].
- Half load: selects bits [15:0] when offset[1]=0, bits [31:16] when offset[1]=1; offset[0] is ignored.
- The selected field SHALL be zero-extended, or sign-extended when Load_Signed is 1.
REQ-012 Write_Register_WB and Write_Data_WB SHALL hold their last value in EMPTY and LOAD_WAIT; only RegWrite_WB qualifies them.
REQ-013 Mem_Rdata_Valid SHALL be ignored in EMPTY, ALU_READY and LOAD_READY unless an instruction with MemToReg_MEM=1 is captured at that same edge.

Reset
REQ-014 Reset_n=0 SHALL immediately force the following, independent of Clk:
- state EMPTY;
- Write_Register_WB=0, Write_Data_WB=0, RegWrite_WB=0;
- Stall_WB=0, ID_Register_Write_to_Read=00.
REQ-015 Reset asserted in LOAD_WAIT SHALL abandon the load; a Mem_Rdata_Valid arriving after reset release SHALL be ignored.
REQ-016 The first capture after reset release SHALL occur at the first rising edge with Reset_n=1.

Configuration
REQ-017 Macro WB_LOAD_ALIGN_EN SHALL control sub-word load handling:
- Defined: the REQ-011 alignment and extension is compiled in.
- Undefined: Mem_Rdata SHALL be written unmodified for every load; Load_Size_MEM, Load_Signed_MEM and the offset bits are unused.
- All other behaviour is identical in both builds.

Verification
REQ-018 ALU write: Valid_MEM=1, RegWrite=1, dest=5, ALU_Result=0x1234_5678 -> next cycle RegWrite_WB=1, Write_Register_WB=5, Write_Data_WB=0x1234_5678.
REQ-019 Load stall: load to dest=9 with Mem_Rdata_Valid low for 3 cycles -> Stall_WB=1 for 3 cycles, RegWrite_WB=0. Then Mem_Rdata=0xCAFE_F00D valid -> next cycle RegWrite_WB=1, data 0xCAFE_F00D.
REQ-020 Alignment (macro defined): Mem_Rdata=0x80FF_7F01.
- Signed byte, offset 3 -> 0xFFFF_FF80.
- Unsigned half, offset 2 -> 0x0000_80FF.
- Signed byte, offset 1 -> 0x0000_007F.
- Macro undefined -> 0x80FF_7F01 in every case.
REQ-021 Bypass: dest=7 with RegWrite_WB=1 and Read_Address_1_ID=7, Read_Address_2_ID=3 -> ID_Register_Write_to_Read=01. Both addresses 7 -> 11. dest=0 -> 00 and RegWrite_WB=0.
REQ-022 Flush and reset:
- Flush_WB=1 in LOAD_WAIT -> EMPTY next cycle, Stall_WB=0; a later Mem_Rdata_Valid is ignored.
- Reset_n low mid-cycle in ALU_READY -> RegWrite_WB=0 immediately.
